// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: walks DIGIT-bit slices MSB-first, exits on the first mismatch.
// Optional two's-complement mode is enabled by defining SEQ_MAG_COMPARATOR_SIGNED_EN.
module seq_mag_comparator #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_MAG_COMPARATOR_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int unsigned NumSlices = WIDTH / DIGIT;
  localparam int unsigned IdxW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;

  typedef enum logic [0:0] {StIdle, StCompare} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IdxW-1:0]  r_idx;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic [WIDTH-1:0] w_msb_flip;
  logic [DIGIT-1:0] w_slice_a;
  logic [DIGIT-1:0] w_slice_b;
  logic             w_accept;
  logic             w_compare;
  logic             w_slice_ne;
  logic             w_last;

  // Inverting both MSBs maps two's complement ordering onto unsigned ordering.
`ifdef SEQ_MAG_COMPARATOR_SIGNED_EN
  assign w_msb_flip = {signed_mode, {(WIDTH-1){1'b0}}};
`else
  assign w_msb_flip = '0;
`endif

  assign w_accept   = start && (r_state == StIdle);
  assign w_compare  = (r_state == StCompare);
  assign w_slice_a  = r_a[WIDTH-1 -: DIGIT];
  assign w_slice_b  = r_b[WIDTH-1 -: DIGIT];
  assign w_slice_ne = (w_slice_a != w_slice_b);
  assign w_last     = (r_idx == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_nxt = StCompare;
        end
      end
      StCompare: begin
        if (w_slice_ne || w_last) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    unique case (r_state)
      StIdle:    busy = 1'b0;
      StCompare: busy = 1'b1;
      default:   busy = 1'b0;
    endcase
  end

  // Operands shift left so the slice under test is always the top DIGIT bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_idx  <= '0;
      r_done <= 1'b0;
      r_gt   <= 1'b0;
      r_eq   <= 1'b0;
      r_lt   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a   <= a ^ w_msb_flip;
        r_b   <= b ^ w_msb_flip;
        r_idx <= IdxW'(NumSlices - 1);
      end else if (w_compare) begin
        if (w_slice_ne) begin
          r_gt   <= (w_slice_a > w_slice_b);
          r_lt   <= (w_slice_a < w_slice_b);
          r_eq   <= 1'b0;
          r_done <= 1'b1;
        end else if (w_last) begin
          r_gt   <= 1'b0;
          r_lt   <= 1'b0;
          r_eq   <= 1'b1;
          r_done <= 1'b1;
        end else begin
          r_a   <= r_a << DIGIT;
          r_b   <= r_b << DIGIT;
          r_idx <= r_idx - IdxW'(1);
        end
      end
    end
  end

  assign done = r_done;
  assign gt   = r_gt;
  assign eq   = r_eq;
  assign lt   = r_lt;

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed self-checking bench for seq_mag_comparator (WIDTH=8, DIGIT=2).
// Covers the signed-mode vectors when SEQ_MAG_COMPARATOR_SIGNED_EN is defined.
module tb_seq_mag_comparator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       signed_mode;
  logic       busy;
  logic       done;
  logic       gt;
  logic       eq;
  logic       lt;

  int n_checks;
  int n_errors;

  seq_mag_comparator #(
    .WIDTH(8),
    .DIGIT(2)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
`ifdef SEQ_MAG_COMPARATOR_SIGNED_EN
    .signed_mode(signed_mode),
`endif
    .busy       (busy),
    .done       (done),
    .gt         (gt),
    .eq         (eq),
    .lt         (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  // Start a compare, measure accept-to-done cycles, check result, pulse width and hold.
  task automatic run_cmp(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input int exp_lat, input logic [2:0] exp_res);
    int cyc;
    a     = va;
    b     = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(cyc);
    check({tag, " lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, " res"}, 32'({gt, eq, lt}), 32'(exp_res));
    check({tag, " busy@done"}, 32'(busy), 32'd0);
    tick();
    check({tag, " pulse"}, 32'({done, gt, eq, lt}), 32'({1'b0, exp_res}));
  endtask

  initial begin
    int cyc;
    int n_done;
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    start       = 1'b0;
    a           = '0;
    b           = '0;
    signed_mode = 1'b0;

    tick();
    tick();
    check("reset", 32'({busy, done, gt, eq, lt}), 32'h0);
    rst = 1'b0;

    // {gt, eq, lt}
    run_cmp("c0_40", 8'hC0, 8'h40, 1, 3'b100);
    run_cmp("01_02", 8'h01, 8'h02, 4, 3'b001);
    run_cmp("a5_a5", 8'hA5, 8'hA5, 4, 3'b010);
    run_cmp("80_7f", 8'h80, 8'h7F, 1, 3'b100);
    run_cmp("34_38", 8'h34, 8'h38, 3, 3'b001);
    run_cmp("5a_5b", 8'h5A, 8'h5B, 4, 3'b001);

    // Start while busy must be ignored, operand changes must not leak in.
    a     = 8'h00;
    b     = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a     = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    check("ign lat", 32'(cyc + 2), 32'd4);
    check("ign res", 32'({gt, eq, lt}), 32'b010);
    // Back-to-back start in the done cycle.
    a     = 8'h10;
    b     = 8'h0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b busy", 32'(busy), 32'd1);
    wait_done(cyc);
    check("b2b lat", 32'(cyc), 32'd2);
    check("b2b res", 32'({gt, eq, lt}), 32'b100);
    tick();
    tick();
    tick();
    check("b2b hold", 32'({busy, done, gt, eq, lt}), 32'b00100);

    // Abort in the second compare cycle.
    a     = 8'h01;
    b     = 8'h02;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort outs", 32'({busy, done, gt, eq, lt}), 32'h0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) n_done++;
    end
    check("abort nodone", 32'(n_done), 32'd0);
    run_cmp("33_33", 8'h33, 8'h33, 4, 3'b010);

`ifdef SEQ_MAG_COMPARATOR_SIGNED_EN
    signed_mode = 1'b1;
    run_cmp("s80_7f", 8'h80, 8'h7F, 1, 3'b001);
    signed_mode = 1'b0;
    run_cmp("u80_7f", 8'h80, 8'h7F, 1, 3'b100);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_mag_comparator.md
SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal values are 2..64.
REQ-002 The block SHALL have parameter DIGIT, default 2, meaning bits examined per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to compare a and b.
REQ-006 The block SHALL have ports a and b, each input, WIDTH bits: operands, sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: comparison in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when the result updates.
REQ-009 The block SHALL have ports gt, eq and lt, each output, 1 bit: a>b, a==b and a<b respectively.

Function
REQ-010 The FSM SHALL have exactly two states, IDLE and COMPARE; busy SHALL be 1 only in COMPARE.
REQ-011 Start accept: start SHALL be accepted only when busy==0; start while busy SHALL be ignored and SHALL NOT re-latch operands.
REQ-012 On the accepting edge, a and b SHALL be latched internally, the slice index SHALL be set to the MSB slice, and the state SHALL become COMPARE.
REQ-013 Each edge in COMPARE SHALL compare one DIGIT-wide slice of the latched operands, MSB slice first, then advance one slice toward the LSB.
REQ-014 First unequal slice (early exit): on that edge, gt/lt SHALL take the slice result, eq SHALL be 0, done SHALL be 1, and the state SHALL become IDLE.
REQ-015 All slices equal: on the edge examining the LSB slice, eq SHALL be 1, gt and lt SHALL be 0, done SHALL be 1, and the state SHALL become IDLE.
REQ-016 Latency: for start accepted at edge k with first mismatch in slice i (0 = MSB slice), done SHALL assert after edge k+1+i; equal operands SHALL take WIDTH/DIGIT cycles.
REQ-017 Exactly one of gt, eq and lt SHALL be 1 after any completed compare; results SHALL hold unchanged until the next done.
REQ-018 done SHALL be 1 for exactly one cycle per accepted start.
REQ-019 busy SHALL fall on the same edge that done rises.
REQ-020 Back-to-back: a start asserted in the cycle done==1 SHALL be accepted, since busy==0 in that cycle.
REQ-021 Changes on a and b while busy SHALL NOT affect the result in progress.

Reset
REQ-022 While rst==1 at an edge, the state SHALL become IDLE and busy, done, gt, eq and lt SHALL all be 0.
REQ-023 rst SHALL take priority over start.
REQ-024 rst mid-compare SHALL abort the compare with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-025 Macro SEQ_MAG_COMPARATOR_SIGNED_EN defined: the block SHALL add input port signed_mode (1 bit), sampled with the operands.
REQ-026 With signed_mode==1 latched, operands SHALL be compared as two's complement by inverting the MSB of both operands before slicing; latency SHALL be unchanged.
REQ-027 Macro not defined: the signed_mode port SHALL be absent and all compares SHALL be unsigned.

Verification (WIDTH=8, DIGIT=2)
REQ-028 Reset: assert rst for 2 cycles -> busy, done, gt, eq and lt all 0.
REQ-029 Early exit: a=0xC0, b=0x40 -> done 1 cycle after accept, gt=1; a=0x01, b=0x02 -> done 4 cycles after accept, lt=1.
REQ-030 Equal: a=b=0xA5 -> done after 4 cycles, eq=1, done high exactly one cycle.
REQ-031 Ignore-while-busy and back-to-back: with a=b=0x00 compare running, pulse start with a=0xFF -> ignored, eq=1; then start in the done cycle with a=0x10, b=0x0F -> accepted, gt=1.
REQ-032 Abort: rst in the 2nd COMPARE cycle -> no done pulse, outputs 0; the next compare with a=0x33, b=0x33 -> eq=1.
REQ-033 Signed mode (macro defined): signed_mode=1, a=0x80, b=0x7F -> lt=1; signed_mode=0 with the same operands -> gt=1.
